// File: rtl/shifter_pkg.sv
// rtl/shifter_pkg.sv - shared encodings and FSM state type for the sequential shifter
package shifter_pkg;

  localparam logic [1:0] SHIFT_LOGICAL = 2'b00;
  localparam logic [1:0] SHIFT_ARITH   = 2'b01;
  localparam logic [1:0] SHIFT_ROTATE  = 2'b10;

  localparam logic SHIFT_LEFT  = 1'b1;
  localparam logic SHIFT_RIGHT = 1'b0;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

endpackage

// File: rtl/shift_stage.sv
// rtl/shift_stage.sv - combinational shift of one value by 0..STEP positions
module shift_stage
  import shifter_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int STEP  = 1,
  localparam int KW    = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] value_i,
  input  logic [KW-1:0]    k_i,
  input  logic             dir_i,
  input  logic [1:0]       mode_i,
  input  logic             sign_i,
  output logic [WIDTH-1:0] value_o,
  output logic             carry_o
);

  logic [WIDTH-1:0]   fill;
  logic [2*WIDTH:0]   ext;

  // The extra guard bit at the far end catches the last bit pushed out.
  always_comb begin
    fill    = '0;
    ext     = '0;
    value_o = '0;
    carry_o = 1'b0;
    if (dir_i == SHIFT_LEFT) begin
      fill    = (mode_i == SHIFT_ROTATE) ? value_i : '0;
      ext     = {1'b0, value_i, fill} << k_i;
      value_o = ext[2*WIDTH-1:WIDTH];
      carry_o = ext[2*WIDTH];
    end else begin
      if (mode_i == SHIFT_ROTATE)
        fill = value_i;
      else if (mode_i == SHIFT_ARITH)
        fill = {WIDTH{sign_i}};
      ext     = {fill, value_i, 1'b0} >> k_i;
      value_o = ext[WIDTH:1];
      carry_o = ext[0];
    end
  end

endmodule

// File: rtl/seq_shifter.sv
// rtl/seq_shifter.sv - multi-cycle shift/rotate unit with start/busy/done handshake
module seq_shifter
  import shifter_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int STEP  = 1,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] src,
  input  logic [AMT_W-1:0] shiftAmt,
  input  logic             shiftDirection,
  input  logic [1:0]       shiftMode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] shiftOut,
  output logic             carryOut
);

  localparam int               KW     = $clog2(STEP + 1);
  localparam logic [AMT_W-1:0] STEP_A = AMT_W'(STEP);

  state_e           state_q;
  logic [WIDTH-1:0] work_q;
  logic [AMT_W-1:0] rem_q;
  logic             dir_q;
  logic [1:0]       mode_q;
  logic             sign_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] shift_out_q;
  logic             carry_out_q;

  logic [KW-1:0]    k_d;
  logic [AMT_W-1:0] rem_d;
  logic [WIDTH-1:0] work_d;
  logic             carry_d;

  always_comb begin
    k_d   = (rem_q >= STEP_A) ? KW'(STEP) : KW'(rem_q);
    rem_d = rem_q - AMT_W'(k_d);
  end

  shift_stage #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_stage (
    .value_i (work_q),
    .k_i     (k_d),
    .dir_i   (dir_q),
    .mode_i  (mode_q),
    .sign_i  (sign_q),
    .value_o (work_d),
    .carry_o (carry_d)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      work_q      <= '0;
      rem_q       <= '0;
      dir_q       <= 1'b0;
      mode_q      <= 2'b00;
      sign_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      shift_out_q <= '0;
      carry_out_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
          if (start) begin
            work_q <= src;
            rem_q  <= shiftAmt;
            dir_q  <= shiftDirection;
            mode_q <= shiftMode;
            sign_q <= src[WIDTH-1];
            if (shiftAmt != '0) begin
              state_q <= SHIFT;
              busy_q  <= 1'b1;
            end else begin
              state_q     <= DONE;
              done_q      <= 1'b1;
              shift_out_q <= src;
              carry_out_q <= 1'b0;
            end
          end
        end
        SHIFT: begin
          work_q <= work_d;
          rem_q  <= rem_d;
          // Outputs are loaded on the same edge that enters DONE.
          if (rem_d == '0) begin
            state_q     <= DONE;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            shift_out_q <= work_d;
            carry_out_q <= carry_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign shiftOut = shift_out_q;
  assign carryOut = carry_out_q;

endmodule

// File: tb/tb_seq_shifter.sv
// tb/tb_seq_shifter.sv - self-checking bench for seq_shifter at WIDTH=16, STEP=4
module tb_seq_shifter;

  localparam int W = 16;
  localparam int S = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] src = '0;
  logic [3:0]  shiftAmt = '0;
  logic        shiftDirection = 1'b0;
  logic [1:0]  shiftMode = 2'b00;
  logic        busy;
  logic        done;
  logic [15:0] shiftOut;
  logic        carryOut;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  logic        m_busy = 1'b0, m_done = 1'b0, m_carry = 1'b0, p_carry = 1'b0;
  logic [15:0] m_out = '0, p_out = '0;
  int          m_cnt = 0;

  seq_shifter #(.WIDTH(W), .STEP(S)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .src            (src),
    .shiftAmt       (shiftAmt),
    .shiftDirection (shiftDirection),
    .shiftMode      (shiftMode),
    .busy           (busy),
    .done           (done),
    .shiftOut       (shiftOut),
    .carryOut       (carryOut)
  );

  always #5 clk = ~clk;

  function automatic void ref_shift(input logic [15:0] s, input int n, input logic dir,
                                    input logic [1:0] mode, output logic [15:0] r, output logic c);
    logic [15:0] t;
    if (n == 0) begin
      r = s;
      c = 1'b0;
    end else if (dir) begin
      t = s >> (W - n);
      c = t[0];
      r = (mode == 2'b10) ? ((s << n) | (s >> (W - n))) : (s << n);
    end else begin
      t = s >> (n - 1);
      c = t[0];
      if (mode == 2'b10)      r = (s >> n) | (s << (W - n));
      else if (mode == 2'b01) r = 16'($signed(s) >>> n);
      else                    r = s >> n;
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: result computed at acceptance, released after ceil(n/STEP) busy cycles.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy = 1'b0; m_done = 1'b0; m_out = '0; m_carry = 1'b0; m_cnt = 0;
    end else if (m_busy) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_busy = 1'b0; m_done = 1'b1; m_out = p_out; m_carry = p_carry;
      end
    end else begin
      m_done = 1'b0;
      if (start) begin
        ref_shift(src, int'(shiftAmt), shiftDirection, shiftMode, p_out, p_carry);
        m_cnt = (int'(shiftAmt) + S - 1) / S;
        if (m_cnt == 0) begin
          m_done = 1'b1; m_out = p_out; m_carry = p_carry;
        end else begin
          m_busy = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      check("cyc_busy",     32'(busy),     32'(m_busy));
      check("cyc_done",     32'(done),     32'(m_done));
      check("cyc_shiftOut", 32'(shiftOut), 32'(m_out));
      check("cyc_carryOut", 32'(carryOut), 32'(m_carry));
    end
  end

  task automatic run_op(input string name, input logic [15:0] s, input logic [3:0] n,
                        input logic dir, input logic [1:0] mode, input logic [15:0] er,
                        input logic ec, input int elat, input int ebusy, input int poke);
    int cyc, bcnt;
    bit got;
    src = s; shiftAmt = n; shiftDirection = dir; shiftMode = mode; start = 1'b1;
    @(negedge clk);
    start = 1'b0; cyc = 1; bcnt = 0; got = 1'b0;
    while (cyc <= 40 && !got) begin
      if (done) got = 1'b1;
      else begin
        if (busy) bcnt++;
        start = (cyc == poke);
        if (start) begin
          src = 16'hFFFF; shiftAmt = 4'd1; shiftDirection = 1'b1; shiftMode = 2'b10;
        end
        @(negedge clk);
        start = 1'b0;
        cyc++;
      end
    end
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL %s_timeout: no done within 40 cycles", name);
    end else begin
      check({name, "_latency"},  32'(cyc),      32'(elat));
      check({name, "_busycyc"},  32'(bcnt),     32'(ebusy));
      check({name, "_shiftOut"}, 32'(shiftOut), 32'(er));
      check({name, "_carryOut"}, 32'(carryOut), 32'(ec));
    end
  endtask

  initial begin
    int seen;
    repeat (2) @(negedge clk);
    check("rst_busy",     32'(busy),     32'(0));
    check("rst_done",     32'(done),     32'(0));
    check("rst_shiftOut", 32'(shiftOut), 32'(0));
    check("rst_carryOut", 32'(carryOut), 32'(0));
    reset = 1'b0;
    check_en = 1'b1;
    @(negedge clk);

    run_op("lsl4",    16'h00F1, 4'd4,  1'b1, 2'b00, 16'h0F10, 1'b0, 2, 1, 0);
    repeat (2) @(negedge clk);
    run_op("asr15",   16'h8000, 4'd15, 1'b0, 2'b01, 16'hFFFF, 1'b0, 5, 4, 0);
    repeat (2) @(negedge clk);
    run_op("ror1",    16'h0001, 4'd1,  1'b0, 2'b10, 16'h8000, 1'b1, 2, 1, 0);
    run_op("rol1_b2b",16'h8000, 4'd1,  1'b1, 2'b10, 16'h0001, 1'b1, 2, 1, 0);
    repeat (2) @(negedge clk);
    run_op("zero",    16'hA5A5, 4'd0,  1'b0, 2'b00, 16'hA5A5, 1'b0, 1, 0, 0);
    repeat (2) @(negedge clk);
    run_op("lsr15",   16'h4000, 4'd15, 1'b0, 2'b00, 16'h0000, 1'b1, 5, 4, 2);
    repeat (2) @(negedge clk);
    run_op("asl2",    16'hC003, 4'd2,  1'b1, 2'b01, 16'h000C, 1'b1, 2, 1, 0);
    repeat (2) @(negedge clk);
    run_op("rol7",    16'h1234, 4'd7,  1'b1, 2'b10, 16'h1A09, 1'b1, 3, 2, 0);
    repeat (2) @(negedge clk);

    src = 16'h00FF; shiftAmt = 4'd12; shiftDirection = 1'b1; shiftMode = 2'b00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_busy",     32'(busy),     32'(0));
    check("abort_done",     32'(done),     32'(0));
    check("abort_shiftOut", 32'(shiftOut), 32'(0));
    check("abort_carryOut", 32'(carryOut), 32'(0));
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("abort_no_done", 32'(seen), 32'(0));
    run_op("after_rst", 16'h0001, 4'd12, 1'b1, 2'b11, 16'h1000, 1'b0, 4, 3, 0);
    repeat (2) @(negedge clk);

    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
